// File: rtl/bank_timing_tracker.sv
// bank_timing_tracker
// Per-bank DDR timing state tracker for the emulated DIMM. Consumes decoded,
// chip-selected commands and keeps one timing state machine per bank, plus a
// refresh-interval tracker. The published bank states gate the memory cache.
//
// Optional feature macro: TIMING_VIOLATION_EN
//   defined   -> illegal commands pulse violation, capture viol_bank and
//                increment the saturating viol_cnt
//   undefined -> illegal commands are silently dropped; violation outputs are 0
//
// Ports:
//   ck_tp        clock, rising edge active
//   reset_n      asynchronous active-low reset
//   cmd_valid    command present this cycle (already qualified by chip select)
//   cmd[2:0]     0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 PREA, 6 REF, 7 reserved (NOP)
//   bg, ba       target bank group / bank
//   bank_state   5-bit state of bank idx = bg*BANKSPERGROUP+ba at [5*idx +: 5]
//   all_idle     every bank IDLE
//   refresh_due  T_REFI cycles elapsed since the last accepted REF
//   violation    one-cycle pulse, an illegal command was rejected
//   viol_bank    {bg,ba} of the last violation
//   viol_cnt     saturating violation count
//
// Handshake: there is no ready/backpressure. A command is sampled on every
// rising edge where cmd_valid is high; it is either accepted (legal) or
// dropped (illegal). Legality is always judged on the registered state
// visible before that edge.
module bank_timing_tracker #(
  parameter int BGWIDTH = 2,
  parameter int BAWIDTH = 2,
  parameter int T_RCD   = 17,
  parameter int T_RP    = 17,
  parameter int T_RAS   = 32,
  parameter int T_ABA   = 24,
  parameter int T_ABAR  = 24,
  parameter int T_RFC   = 34,
  parameter int T_REFI  = 9360
) (
  input  logic                                   ck_tp,
  input  logic                                   reset_n,
  input  logic                                   cmd_valid,
  input  logic [2:0]                             cmd,
  input  logic [BGWIDTH-1:0]                     bg,
  input  logic [BAWIDTH-1:0]                     ba,
  output logic [5*(2**(BGWIDTH+BAWIDTH))-1:0]    bank_state,
  output logic                                   all_idle,
  output logic                                   refresh_due,
  output logic                                   violation,
  output logic [BGWIDTH+BAWIDTH-1:0]             viol_bank,
  output logic [7:0]                             viol_cnt
);
  localparam int IW = BGWIDTH + BAWIDTH;
  localparam int NB = 2**IW;

  // Transient states load T-1 and leave on the edge where the count is 0,
  // so each transient state is visible for exactly T cycles.
  localparam logic [15:0] RCD_LD   = 16'(T_RCD - 1);
  localparam logic [15:0] RP_LD    = 16'(T_RP - 1);
  localparam logic [15:0] ABA_LD   = 16'(T_ABA - 1);
  localparam logic [15:0] ABAR_LD  = 16'(T_ABAR - 1);
  localparam logic [15:0] RFC_LD   = 16'(T_RFC - 1);
  localparam logic [15:0] TRAS_MAX = 16'(T_RAS);
  localparam logic [15:0] REFI_MAX = 16'(T_REFI);

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_PREA = 3'd5;
  localparam logic [2:0] CMD_REF  = 3'd6;
  localparam logic [2:0] CMD_RSV  = 3'd7;

  typedef enum logic [4:0] {
    S_IDLE        = 5'h00,
    S_ACTIVATING  = 5'h01,
    S_ACTIVE      = 5'h03,
    S_PRECHARGING = 5'h0A,
    S_READING     = 5'h0B,
    S_WRITING     = 5'h12,
    S_REFRESHING  = 5'h0C
  } bank_st_e;

  bank_st_e    state_q [NB];
  logic [15:0] cnt_q   [NB];
  logic [15:0] tras_q  [NB];
  logic [15:0] refi_q;
  logic [15:0] refi_next;

  logic [IW-1:0] tgt;
  logic [NB-1:0] sel;
  bank_st_e      tgt_st;
  logic [15:0]   tgt_tras;
  logic          prea_block;
  logic          busy;
  logic          act_ok, rd_ok, wr_ok, pre_ok, prea_ok, ref_ok;

  assign tgt      = {bg, ba};
  assign sel      = NB'(1) << tgt;
  assign tgt_st   = state_q[tgt];
  assign tgt_tras = tras_q[tgt];

`ifdef TIMING_VIOLATION_EN
  logic [IW-1:0] prea_bad;
  logic [IW-1:0] ref_bad;
  logic [IW-1:0] viol_idx;
  logic          illegal;
`endif

  // Scan banks in index order: PREA is blocked by any transient bank or any
  // ACTIVE bank short of tRAS; REF is blocked by any non-IDLE bank. The first
  // offender is remembered for violation reporting.
  always_comb begin
    prea_block = 1'b0;
    busy       = 1'b0;
`ifdef TIMING_VIOLATION_EN
    prea_bad   = '0;
    ref_bad    = '0;
`endif
    for (int i = 0; i < NB; i++) begin
      if (!prea_block &&
          ((state_q[i] != S_IDLE && state_q[i] != S_ACTIVE) ||
           (state_q[i] == S_ACTIVE && tras_q[i] < TRAS_MAX))) begin
        prea_block = 1'b1;
`ifdef TIMING_VIOLATION_EN
        prea_bad   = IW'(i);
`endif
      end
      if (!busy && state_q[i] != S_IDLE) begin
        busy    = 1'b1;
`ifdef TIMING_VIOLATION_EN
        ref_bad = IW'(i);
`endif
      end
    end
  end

  assign act_ok  = cmd_valid && cmd == CMD_ACT && tgt_st == S_IDLE;
  assign rd_ok   = cmd_valid && cmd == CMD_RD  && tgt_st == S_ACTIVE;
  assign wr_ok   = cmd_valid && cmd == CMD_WR  && tgt_st == S_ACTIVE;
  // PRE to an IDLE bank is accepted but changes nothing.
  assign pre_ok  = cmd_valid && cmd == CMD_PRE &&
                   (tgt_st == S_IDLE || (tgt_st == S_ACTIVE && tgt_tras >= TRAS_MAX));
  assign prea_ok = cmd_valid && cmd == CMD_PREA && !prea_block;
  assign ref_ok  = cmd_valid && cmd == CMD_REF  && !busy;
  assign all_idle = !busy;

  always_comb begin
    bank_state = '0;
    for (int i = 0; i < NB; i++) begin
      bank_state[5*i +: 5] = state_q[i];
    end
  end

  always_ff @(posedge ck_tp or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NB; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        tras_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (tras_q[i] < TRAS_MAX) tras_q[i] <= tras_q[i] + 16'd1;
        case (state_q[i])
          S_IDLE: begin
            if (act_ok && sel[i]) begin
              state_q[i] <= S_ACTIVATING;
              cnt_q[i]   <= RCD_LD;
              tras_q[i]  <= '0;
            end else if (ref_ok) begin
              state_q[i] <= S_REFRESHING;
              cnt_q[i]   <= RFC_LD;
            end
          end
          S_ACTIVE: begin
            if (rd_ok && sel[i]) begin
              state_q[i] <= S_READING;
              cnt_q[i]   <= ABAR_LD;
            end else if (wr_ok && sel[i]) begin
              state_q[i] <= S_WRITING;
              cnt_q[i]   <= ABA_LD;
            end else if ((pre_ok && sel[i]) || prea_ok) begin
              state_q[i] <= S_PRECHARGING;
              cnt_q[i]   <= RP_LD;
            end
          end
          S_ACTIVATING, S_READING, S_WRITING: begin
            if (cnt_q[i] == '0) state_q[i] <= S_ACTIVE;
            else                cnt_q[i]   <= cnt_q[i] - 16'd1;
          end
          S_PRECHARGING, S_REFRESHING: begin
            if (cnt_q[i] == '0) state_q[i] <= S_IDLE;
            else                cnt_q[i]   <= cnt_q[i] - 16'd1;
          end
          default: state_q[i] <= S_IDLE;
        endcase
      end
    end
  end

  // Refresh interval counter saturates at T_REFI; an accepted REF restarts it
  // and takes priority over the flag rising in the same cycle.
  always_comb begin
    if (ref_ok)                  refi_next = '0;
    else if (refi_q == REFI_MAX) refi_next = refi_q;
    else                         refi_next = refi_q + 16'd1;
  end

  always_ff @(posedge ck_tp or negedge reset_n) begin
    if (!reset_n) begin
      refi_q      <= '0;
      refresh_due <= 1'b0;
    end else begin
      refi_q      <= refi_next;
      refresh_due <= (refi_next == REFI_MAX);
    end
  end

`ifdef TIMING_VIOLATION_EN
  // Reserved and NOP codes are never violations; every other code is illegal
  // exactly when its acceptance condition is false.
  assign illegal  = cmd_valid && cmd != CMD_NOP && cmd != CMD_RSV &&
                    !(act_ok || rd_ok || wr_ok || pre_ok || prea_ok || ref_ok);
  assign viol_idx = (cmd == CMD_PREA) ? prea_bad :
                    (cmd == CMD_REF)  ? ref_bad  : tgt;

  always_ff @(posedge ck_tp or negedge reset_n) begin
    if (!reset_n) begin
      violation <= 1'b0;
      viol_bank <= '0;
      viol_cnt  <= '0;
    end else begin
      violation <= illegal;
      if (illegal) begin
        viol_bank <= viol_idx;
        if (viol_cnt != 8'hFF) viol_cnt <= viol_cnt + 8'd1;
      end
    end
  end
`else
  assign violation = 1'b0;
  assign viol_bank = '0;
  assign viol_cnt  = '0;
`endif

endmodule
